alu_op_issue: RTL
=================

// Module: alu_op_issue
// PURPOSE
//  Decode-to-execute issue stage; drives the ALU interface from the producer side.
//  - Accepts one RV32I integer instruction plus PC and register-file read data.
//  - Produces the eight one-hot ALU operation strobes and both ALU operands,
//    held in a pipeline register with a valid/ready handshake.
//  - Sits between the register-file read and the ALU in the execute unit.
// PARAMETERS
//  X_LENGTH  `X_LENGTH (32)  datapath width of PC, register data and operands
// PORTS
//  clk                              in   1         rising-edge clock
//  rst                              in   1         synchronous reset, active-high
//  flush                            in   1         drop all held and incoming instructions
//  in_valid                         in   1         upstream offers an instruction
//  in_ready                         out  1         stage accepts the offer this cycle
//  in_instruction                   in   32        raw instruction word
//  in_pc                            in   X_LENGTH  instruction address
//  in_rs1_data                      in   X_LENGTH  rs1 register value
//  in_rs2_data                      in   X_LENGTH  rs2 register value
//  out_valid                        out  1         operation and operands are valid
//  out_ready                        in   1         ALU side consumes this cycle
//  out_illegal                      out  1         held instruction is not ALU-executable
//  operation_add                    out  1         one-hot op strobe
//  operation_subtract               out  1         one-hot op strobe
//  operation_and                    out  1         one-hot op strobe
//  operation_or                     out  1         one-hot op strobe
//  operation_xor                    out  1         one-hot op strobe
//  operation_shift_left_logical     out  1         one-hot op strobe
//  operation_shift_right_arithmetic out  1         one-hot op strobe
//  operation_shift_right_logical    out  1         one-hot op strobe
//  operand_1                        out  X_LENGTH  ALU operand 1
//  operand_2                        out  X_LENGTH  ALU operand 2
// BEHAVIOUR
//  - Reset: out_valid, out_illegal, all op strobes, operand_1 and operand_2 = 0; skid empty.
//  - Handshake:
//    - Accept when in_valid && in_ready. Transfer out when out_valid && out_ready.
//    - Latency is 1 cycle from acceptance to out_valid.
//    - Outputs are stable while out_valid && !out_ready.
//  - in_ready = !out_valid || out_ready (combinational pass-through when the skid is absent).
//  - Decode, by opcode [6:0]:
//    - 0110011 (OP): operand_1 = rs1, operand_2 = rs2.
//    - 0010011 (OP-IMM): operand_1 = rs1, operand_2 = sign-extended inst[31:20].
//      For shifts, operand_2 = zero-extended inst[24:20].
//    - 0110111 (LUI): add; operand_1 = 0, operand_2 = {inst[31:12], 12'b0}.
//    - 0010111 (AUIPC): add; operand_1 = pc, operand_2 = {inst[31:12], 12'b0}.
//  - funct3 map:
//    - 000: add; subtract only for OP with inst[30] = 1.
//    - 001: shift_left_logical.
//    - 100: xor.
//    - 101: shift_right_arithmetic if inst[30] = 1, else shift_right_logical.
//    - 110: or.
//    - 111: and.
//  - Illegal: funct3 010/011 (no ALU support) or any other opcode.
//    - out_illegal = 1, all op strobes = 0, operands = 0.
//    - Still handed over with out_valid = 1.
//  - At most one op strobe is high. All strobes are 0 whenever out_valid = 0.
//  - Flush has priority over everything except rst.
//    - Next cycle: out_valid = 0, strobes = 0, skid empty.
//    - An instruction offered in the flush cycle is discarded.
//  - Reset mid-transfer drops the held instruction. There is no replay.
// CONFIGURATION
//  ALU_ISSUE_SKID_EN defined:
//    - Adds a one-entry skid buffer; in_ready is registered (= skid empty).
//    - An offer accepted while the output is stalled goes into the skid.
//    - The skid moves to the output on the next out transfer, so order is preserved.
//    - Full throughput is kept with no combinational out_ready -> in_ready path.
//  ALU_ISSUE_SKID_EN undefined:
//    - No skid; in_ready is combinational as given above.
// TESTING
//  - Reset: assert rst 2 cycles -> out_valid = 0, every strobe and operand = 0, out_illegal = 0.
//  - add 0x00208033, rs1 = 8, rs2 = -16, out_ready = 1
//    -> next cycle operation_add = 1, operand_1 = 8, operand_2 = 0xFFFFFFF0.
//  - sub 0x40208033, rs1 = -8, rs2 = -16 -> operation_subtract = 1, operands -8 / -16.
//  - srai 0x4040D093, rs1 = -32 -> operation_shift_right_arithmetic = 1, operand_2 = 4.
//  - lui 0x123450B7 -> operation_add = 1, operand_1 = 0, operand_2 = 0x12345000.
//  - slt 0x0020A033 -> out_illegal = 1, all strobes 0.
//  - Stall: hold out_ready = 0 for 3 cycles with back-to-back addi 0xFF000093
//    -> outputs frozen; no instruction lost or duplicated.
//    -> with ALU_ISSUE_SKID_EN, exactly one extra instruction is accepted.
//  - Flush while stalled and in_valid = 1 -> next cycle out_valid = 0; no later output of either instruction.

Source files
------------

// File: rtl/alu_op_issue.sv
// alu_op_issue: RV32I decode-to-execute issue stage.
// Decodes one integer instruction into eight one-hot ALU operation strobes
// plus two operands and holds them in an output register with valid/ready.
// Build option ALU_ISSUE_SKID_EN: adds a one-entry skid buffer so in_ready
// is registered (skid empty) and there is no out_ready -> in_ready path.
// Without it, in_ready = !out_valid || out_ready combinationally.

`ifndef X_LENGTH
`define X_LENGTH 32
`endif

module alu_op_issue #(
    parameter int X_LENGTH = `X_LENGTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instruction,
    input  logic [X_LENGTH-1:0] in_pc,
    input  logic [X_LENGTH-1:0] in_rs1_data,
    input  logic [X_LENGTH-1:0] in_rs2_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_illegal,
    output logic                operation_add,
    output logic                operation_subtract,
    output logic                operation_and,
    output logic                operation_or,
    output logic                operation_xor,
    output logic                operation_shift_left_logical,
    output logic                operation_shift_right_arithmetic,
    output logic                operation_shift_right_logical,
    output logic [X_LENGTH-1:0] operand_1,
    output logic [X_LENGTH-1:0] operand_2
);

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_AND = 2;
    localparam int OP_OR  = 3;
    localparam int OP_XOR = 4;
    localparam int OP_SLL = 5;
    localparam int OP_SRA = 6;
    localparam int OP_SRL = 7;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic                illegal;
        logic [7:0]          op;
        logic [X_LENGTH-1:0] op1;
        logic [X_LENGTH-1:0] op2;
    } payload_t;

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic                alt;
    logic [X_LENGTH-1:0] imm_i;
    logic [X_LENGTH-1:0] imm_u;
    logic [X_LENGTH-1:0] shamt;
    logic                unused_rd;

    assign opcode    = in_instruction[6:0];
    assign funct3    = in_instruction[14:12];
    assign alt       = in_instruction[30];
    assign imm_i     = X_LENGTH'(signed'(in_instruction[31:20]));
    assign imm_u     = X_LENGTH'(signed'({in_instruction[31:12], 12'b0}));
    assign shamt     = X_LENGTH'(in_instruction[24:20]);
    // rd is irrelevant to the ALU; it travels on a separate writeback path.
    assign unused_rd = ^in_instruction[11:7];

    payload_t dec;
    payload_t out_q, out_d;
    logic     out_valid_q, out_valid_d;
    logic     accept;

`ifdef ALU_ISSUE_SKID_EN
    payload_t skid_q, skid_d;
    logic     skid_valid_q, skid_valid_d;
`endif

    // Decode the offered instruction into strobes and operands.
    always_comb begin
        dec = '0;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                dec.op1 = in_rs1_data;
                dec.op2 = (opcode == OPC_OP) ? in_rs2_data : imm_i;
                case (funct3)
                    3'b000: begin
                        if (opcode == OPC_OP && alt) dec.op[OP_SUB] = 1'b1;
                        else                         dec.op[OP_ADD] = 1'b1;
                    end
                    3'b001: begin
                        dec.op[OP_SLL] = 1'b1;
                        if (opcode == OPC_OP_IMM) dec.op2 = shamt;
                    end
                    3'b100: dec.op[OP_XOR] = 1'b1;
                    3'b101: begin
                        if (alt) dec.op[OP_SRA] = 1'b1;
                        else     dec.op[OP_SRL] = 1'b1;
                        if (opcode == OPC_OP_IMM) dec.op2 = shamt;
                    end
                    3'b110: dec.op[OP_OR]  = 1'b1;
                    3'b111: dec.op[OP_AND] = 1'b1;
                    default: begin
                        // slt/sltu family: no ALU support, operands zeroed
                        dec         = '0;
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                dec.op[OP_ADD] = 1'b1;
                dec.op2        = imm_u;
            end
            OPC_AUIPC: begin
                dec.op[OP_ADD] = 1'b1;
                dec.op1        = in_pc;
                dec.op2        = imm_u;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

`ifdef ALU_ISSUE_SKID_EN
    assign in_ready = !skid_valid_q;
`else
    assign in_ready = !out_valid_q || out_ready;
`endif
    assign accept = in_valid && in_ready;

    // Next state of the output register (and skid when present); payload is
    // cleared whenever the output empties so strobes are 0 while invalid.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
`ifdef ALU_ISSUE_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
`endif
        if (flush) begin
            out_valid_d = 1'b0;
            out_d       = '0;
`ifdef ALU_ISSUE_SKID_EN
            skid_valid_d = 1'b0;
            skid_d       = '0;
`endif
        end else begin
`ifdef ALU_ISSUE_SKID_EN
            if (!out_valid_q || out_ready) begin
                if (skid_valid_q) begin
                    // in_ready is low while the skid is full, so no accept here
                    out_valid_d  = 1'b1;
                    out_d        = skid_q;
                    skid_valid_d = 1'b0;
                    skid_d       = '0;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    out_d       = dec;
                end else begin
                    out_valid_d = 1'b0;
                    out_d       = '0;
                end
            end else if (accept) begin
                skid_valid_d = 1'b1;
                skid_d       = dec;
            end
`else
            if (accept) begin
                out_valid_d = 1'b1;
                out_d       = dec;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
                out_d       = '0;
            end
`endif
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
`ifdef ALU_ISSUE_SKID_EN
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
`ifdef ALU_ISSUE_SKID_EN
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
`endif
        end
    end

    assign out_valid                        = out_valid_q;
    assign out_illegal                      = out_q.illegal;
    assign operation_add                    = out_q.op[OP_ADD];
    assign operation_subtract               = out_q.op[OP_SUB];
    assign operation_and                    = out_q.op[OP_AND];
    assign operation_or                     = out_q.op[OP_OR];
    assign operation_xor                    = out_q.op[OP_XOR];
    assign operation_shift_left_logical     = out_q.op[OP_SLL];
    assign operation_shift_right_arithmetic = out_q.op[OP_SRA];
    assign operation_shift_right_logical    = out_q.op[OP_SRL];
    assign operand_1                        = out_q.op1;
    assign operand_2                        = out_q.op2;

endmodule
